// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Types and constants shared by the UART receiver and its FIFO. The default
// bit period is also meant for the UART transmitter, so that both ends of
// the link run at the same baud rate.
//   uart_rx_state_t   : receiver FSM states
//   UART_DATA_BITS    : payload bits per 8N1 frame
//   UART_CLKS_PER_BIT : default bit period (100 MHz / 115200)
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. data_out always shows the head
// entry (zero while empty). Pointers are one bit wider than the index so
// that full and empty can be told apart from their difference alone.
//   clk, rst : clock, synchronous active-high reset
//   push     : write data_in (taken when not full, or when full and popping)
//   pop      : remove the head entry (ignored while empty)
//   data_out : head entry
//   empty    : no entries
//   full     : DEPTH entries
//   count    : current occupancy
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign count = wptr_q - rptr_q;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and data_out is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_in;
    end

    assign data_out = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule : sync_fifo

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver with a programmable bit period. Bytes are assembled
// LSB-first from mid-bit samples and queued in a small FIFO drained by a
// ready/valid consumer.
//   clk, rst   : clock, synchronous active-high reset
//   urx        : asynchronous serial input, idle high
//   rx_data    : byte at the FIFO head
//   rx_valid   : FIFO non-empty
//   rx_ready   : consumer pops the head when rx_valid && rx_ready
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overrun    : one-cycle pulse when a good byte is dropped (FIFO full)
//   fifo_count : current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          urx,
    output logic [UART_DATA_BITS-1:0]     rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q;
    logic                      sync1_q;
    logic                      rxs_q;
    logic [1:0]                sync_vld_q;
    logic                      armed_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_err_q;
    logic                      overrun_q;

    logic                      push_byte;
    logic                      fifo_empty;
    logic                      fifo_full;

    // LSB arrives first: shift right with the new bit entering at the MSB.
    assign shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};

    // Good stop bit: the byte is written into the FIFO on this very cycle.
    assign push_byte = (state_q == STOP) && (cnt_q == CNT_FULL) && rxs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            sync_vld_q  <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q    <= urx;
            rxs_q      <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            // A start bit is a falling edge after reset: the line must first be
            // seen high once the synchronizer holds real line samples, so a
            // reset in the middle of a frame cannot start on its remaining bits.
            if (sync_vld_q[1] && rxs_q) armed_q <= 1'b1;

            frame_err_q <= 1'b0;
            overrun_q   <= push_byte && fifo_full && !rx_ready;

            case (state_q)
                IDLE: begin
                    if (armed_q && !rxs_q) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (rxs_q) begin
                            state_q <= IDLE;        // glitch, not a start bit
                        end else begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        cnt_q     <= '0;
                        if (bit_idx_q == IDX_LAST) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold here while the line stays low so a break reports once.
                    if (rxs_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_byte),
        .data_in  (shift_q),
        .pop      (rx_ready),
        .data_out (rx_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with CLKS_PER_BIT = 8 and FIFO_DEPTH = 4. An
// 8N1 line model drives urx; bytes expected to land in the FIFO are queued
// in a scoreboard and compared as the bench drains the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       urx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_count;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .urx        (urx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb[$];
    int         fe_exp = 0;
    int         ov_exp = 0;

    // Free-running cycle count and pulse monitors, sampled on the falling edge.
    int   cyc = 0;
    int   rise_cyc = 0;
    int   rise_cnt = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   both_cnt = 0;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid && !valid_prev) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        valid_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame. pop_on_push raises rx_ready for exactly the
    // stop-sample cycle; rst_bit >= 0 pulses rst in the middle of that bit.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit pop_on_push, input int rst_bit);
        urx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            urx = b[i];
            if (i == rst_bit) begin
                tick(3);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                tick(CPB - 4);
            end else begin
                tick(CPB);
            end
        end
        urx = stop;
        for (int k = 1; k <= CPB; k++) begin
            tick(1);
            if (pop_on_push && k == CPB - 2) begin
                check("head popped on push cycle", rx_data, sb.pop_front());
                rx_ready = 1'b1;
            end
            if (k == CPB - 1) rx_ready = 1'b0;
        end
        if (rst_bit >= 0) begin
            sb.delete();
        end else if (!stop) begin
            fe_exp++;
        end else if (sb.size() < DEPTH) begin
            sb.push_back(b);
        end else begin
            ov_exp++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        check({tag, " valid"}, rx_valid, 1);
        check({tag, " data"}, rx_data, e);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        int t0;
        int r0;
        int f0;
        int o0;
        rst      = 1'b1;
        urx      = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        check("reset rx_valid", rx_valid, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset rx_data", rx_data, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        rst = 1'b0;
        tick(5);

        // Single byte: latency, data, occupancy, pop.
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        check("A5 latency", rise_cyc - t0, 2 + CPB/2 + 9*CPB + 1);
        check("A5 count", fifo_count, sb.size());
        pop_check("A5");
        check("A5 valid after pop", rx_valid, 0);
        check("A5 count after pop", fifo_count, 0);
        tick(4);

        // Fill the FIFO, then overflow it with no consumer.
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        check("full count", fifo_count, 4);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        check("overrun pulses", ov_cnt, ov_exp);
        check("count after overrun", fifo_count, sb.size());
        for (int i = 0; i < 4; i++) pop_check("drain after overrun");
        check("empty after drain", rx_valid, 0);
        tick(4);

        // Full FIFO with a pop on the fifth byte's push cycle.
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        check("no overrun when popping", ov_cnt, ov_exp);
        check("count after push+pop", fifo_count, sb.size());
        for (int i = 0; i < 4; i++) pop_check("drain push+pop");
        tick(4);

        // Framing error, then a held-low line, then a clean byte.
        send_frame(8'h5A, 1'b0, 1'b0, -1);
        tick(40);
        check("frame_err pulses", fe_cnt, fe_exp);
        check("no push on frame error", fifo_count, 0);
        urx = 1'b1;
        tick(10);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        check("count after break", fifo_count, 1);
        pop_check("after break");
        tick(4);

        // Two-cycle glitch from idle.
        r0 = rise_cnt;
        f0 = fe_cnt;
        o0 = ov_cnt;
        urx = 1'b0;
        tick(2);
        urx = 1'b1;
        tick(30);
        check("glitch rx_valid rises", rise_cnt, r0);
        check("glitch frame_err", fe_cnt, f0);
        check("glitch overrun", ov_cnt, o0);

        // Reset in the middle of bit 4 of 0xC3, then a clean 0x7E.
        r0 = rise_cnt;
        send_frame(8'hC3, 1'b1, 1'b0, 4);
        tick(10);
        check("reset mid-frame count", fifo_count, 0);
        check("reset mid-frame no push", rise_cnt, r0);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        pop_check("after mid-frame reset");
        check("final frame_err total", fe_cnt, fe_exp);
        check("final overrun total", ov_cnt, ov_exp);
        check("flags never together", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_uart_rx
